// File: rtl/cache_arbiter.sv
// ============================================================================
// cache_arbiter -- fair two-client arbiter sharing one memory port between
//                  an I-cache (fills) and a D-cache (fills and writebacks).
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_read_q,   mem_read_d;
    logic                mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [LINE_W-1:0]   i_rdata_q,    i_rdata_d;
    logic [LINE_W-1:0]   d_rdata_q,    d_rdata_d;
    logic                i_resp_q,     i_resp_d;
    logic                d_resp_q,     d_resp_d;

    logic                w_d_pend;
    logic                w_d_wins;

    assign w_d_pend = d_read | d_write;
    // D wins when alone, or on a tie when I was granted most recently.
    assign w_d_wins = w_d_pend && (!i_read || (last_grant_q == GRANT_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_d_wins) begin
                    state_d     = ST_SERVE_D;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_write_d = d_write;
                    mem_read_d  = ~d_write;
                end else if (i_read) begin
                    state_d     = ST_SERVE_I;
                    mem_addr_d  = i_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                end
            end
            ST_SERVE_I: begin
                if (mem_resp) begin
                    state_d      = ST_RELEASE;
                    i_rdata_d    = mem_rdata;
                    i_resp_d     = 1'b1;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = GRANT_I;
                end
            end
            ST_SERVE_D: begin
                if (mem_resp) begin
                    state_d      = ST_RELEASE;
                    // Writebacks return no data; keep the last fill visible.
                    if (mem_read_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_resp_d     = 1'b1;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = GRANT_D;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_resp    = i_resp_q;
    assign d_resp    = d_resp_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// tb_cache_arbiter -- directed self-checking bench for cache_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int checks;
    int errors;
    logic [LINE_W-1:0] exp_i_rdata;
    logic [LINE_W-1:0] exp_d_rdata;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1 ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
        d_wdata = '0; mem_rdata = '0; mem_resp = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        step();
        step();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        i_read = 1; d_write = 1; d_addr = 32'hFFFF_FFFF; d_wdata = '1;
        mem_resp = 1; mem_rdata = '1;
        step();
        step();
        checks++; if (mem_read !== 1'b0)  begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got i=%b d=%b expected 0 0", i_resp, d_resp); end
        checks++; if (i_rdata !== '0)     begin errors++; $display("FAIL reset_i_rdata: got %h expected 0", i_rdata); end
        checks++; if (d_rdata !== '0)     begin errors++; $display("FAIL reset_d_rdata: got %h expected 0", d_rdata); end
        clear_inputs();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    // Request presented in the very first cycle out of reset.
    task automatic test_lone_i();
        int hi_cycles;
        rst = 1; i_read = 1; i_addr = 32'h0000_1000;
        hi_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (mem_read === 1'b1) hi_cycles++;
            if (c == 2) begin
                mem_resp = 1; mem_rdata = {8{32'hA5A5_A5A5}};
            end
        end
        checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lone_i_addr: got %h expected 00001000", mem_addr); end
        step();
        exp_i_rdata = {8{32'hA5A5_A5A5}};
        checks++; if (hi_cycles !== 3 || mem_read !== 1'b0) begin errors++; $display("FAIL lone_i_read_len: got %0d cycles, now %b expected 3 cycles, now 0", hi_cycles, mem_read); end
        checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin errors++; $display("FAIL lone_i_resp: got i=%b d=%b expected 1 0", i_resp, d_resp); end
        checks++; if (i_rdata !== exp_i_rdata) begin errors++; $display("FAIL lone_i_rdata: got %h expected %h", i_rdata, exp_i_rdata); end
        // mem_resp left high through RELEASE must be ignored.
        i_read = 0; mem_rdata = '1;
        step();
        mem_resp = 0;
        checks++; if (i_resp !== 1'b0 || i_rdata !== exp_i_rdata) begin errors++; $display("FAIL release_ignore: got resp=%b rdata=%h expected 0 %h", i_resp, i_rdata, exp_i_rdata); end
        step();
        checks++; if (mem_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("FAIL lone_i_no_dup: got rd=%b i=%b d=%b expected 0 0 0", mem_read, i_resp, d_resp); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200;
        step();
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h200) begin errors++; $display("FAIL sim_first_d: got rd=%b wr=%b addr=%h expected 1 0 00000200", mem_read, mem_write, mem_addr); end
        mem_resp = 1; mem_rdata = {8{32'hD1D1_D1D1}};
        step();
        exp_d_rdata = {8{32'hD1D1_D1D1}};
        checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== exp_d_rdata) begin errors++; $display("FAIL sim_d_done: got d=%b i=%b rdata=%h expected 1 0 %h", d_resp, i_resp, d_rdata, exp_d_rdata); end
        d_read = 0; mem_resp = 0;
        step();
        checks++; if (mem_read !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("FAIL sim_release: got rd=%b d=%b expected 0 0", mem_read, d_resp); end
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL sim_then_i: got rd=%b addr=%h expected 1 00000100", mem_read, mem_addr); end
        mem_resp = 1; mem_rdata = {8{32'hC3C3_C3C3}};
        step();
        exp_i_rdata = {8{32'hC3C3_C3C3}};
        checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== exp_i_rdata) begin errors++; $display("FAIL sim_i_done: got i=%b d=%b rdata=%h expected 1 0 %h", i_resp, d_resp, i_rdata, exp_i_rdata); end
        i_read = 0; mem_resp = 0;
        step();
    endtask

    task automatic test_alternation();
        int w;
        do_reset();
        i_read = 1; i_addr = 32'h0000_0A00; d_read = 1; d_addr = 32'h0000_0B00;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (mem_read !== 1'b1 && w < 8) begin
                step();
                w++;
            end
            checks++; if (w >= 8) begin errors++; $display("FAIL alt_timeout_%0d: got no request expected mem_read within 8 cycles", k); end
            checks++; if (mem_addr !== ((k % 2 == 0) ? 32'h0000_0B00 : 32'h0000_0A00)) begin errors++; $display("FAIL alt_order_%0d: got addr %h expected %s", k, mem_addr, (k % 2 == 0) ? "D" : "I"); end
            mem_resp = 1; mem_rdata = {LINE_W{1'b0}} | k;
            step();
            mem_resp = 0;
            if (k % 2 == 0) begin
                checks++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin errors++; $display("FAIL alt_resp_%0d: got d=%b i=%b expected 1 0", k, d_resp, i_resp); end
            end else begin
                checks++; if (i_resp !== 1'b1 || d_resp !== 1'b0) begin errors++; $display("FAIL alt_resp_%0d: got i=%b d=%b expected 1 0", k, i_resp, d_resp); end
            end
        end
        exp_d_rdata = 256'd2;
        exp_i_rdata = 256'd3;
        checks++; if (d_rdata !== exp_d_rdata || i_rdata !== exp_i_rdata) begin errors++; $display("FAIL alt_rdata: got d=%h i=%h expected %h %h", d_rdata, i_rdata, exp_d_rdata, exp_i_rdata); end
        i_read = 0; d_read = 0;
        step();
        step();
    endtask

    task automatic test_writeback();
        d_write = 1; d_addr = 32'h8000_0040; d_wdata = {16{16'h1234}};
        step();
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL wb_op: got wr=%b rd=%b expected 1 0", mem_write, mem_read); end
        checks++; if (mem_wdata !== {16{16'h1234}}) begin errors++; $display("FAIL wb_wdata: got %h expected 1234 pattern", mem_wdata); end
        d_addr = 32'h0; d_wdata = '0;
        step();
        step();
        checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h8000_0040 || mem_wdata !== {16{16'h1234}}) begin errors++; $display("FAIL wb_hold: got wr=%b addr=%h expected 1 80000040", mem_write, mem_addr); end
        mem_resp = 1; mem_rdata = '1;
        step();
        checks++; if (d_resp !== 1'b1 || mem_write !== 1'b0 || d_rdata !== exp_d_rdata) begin errors++; $display("FAIL wb_done: got resp=%b wr=%b rdata=%h expected 1 0 %h", d_resp, mem_write, d_rdata, exp_d_rdata); end
        d_write = 0; mem_resp = 0;
        step();
        checks++; if (d_resp !== 1'b0) begin errors++; $display("FAIL wb_single_pulse: got %b expected 0", d_resp); end
        d_read = 1; d_write = 1; d_addr = 32'h40;
        step();
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL rw_is_write: got wr=%b rd=%b expected 1 0", mem_write, mem_read); end
        mem_resp = 1;
        step();
        checks++; if (d_resp !== 1'b1 || d_rdata !== exp_d_rdata) begin errors++; $display("FAIL rw_done: got resp=%b rdata=%h expected 1 %h", d_resp, d_rdata, exp_d_rdata); end
        d_read = 0; d_write = 0; mem_resp = 0;
        step();
    endtask

    task automatic test_reset_mid_and_stray();
        int resp_seen;
        i_read = 1; i_addr = 32'h300;
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h300) begin errors++; $display("FAIL mid_start: got rd=%b addr=%h expected 1 00000300", mem_read, mem_addr); end
        step();
        rst = 0;
        step();
        checks++; if (mem_read !== 1'b0 || i_resp !== 1'b0) begin errors++; $display("FAIL mid_abandon: got rd=%b resp=%b expected 0 0", mem_read, i_resp); end
        rst = 1; i_read = 0; mem_resp = 1; mem_rdata = '1;
        resp_seen = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (i_resp !== 1'b0 || d_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) resp_seen++;
        end
        checks++; if (resp_seen !== 0) begin errors++; $display("FAIL stray_idle: got %0d active cycles expected 0", resp_seen); end
        checks++; if (i_rdata !== '0) begin errors++; $display("FAIL stray_rdata: got %h expected 0", i_rdata); end
        mem_resp = 0; d_read = 1; d_addr = 32'h500;
        step();
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL post_stray_grant: got rd=%b addr=%h expected 1 00000500", mem_read, mem_addr); end
        mem_resp = 1; mem_rdata = {8{32'h5A5A_5A5A}};
        step();
        checks++; if (d_resp !== 1'b1 || d_rdata !== {8{32'h5A5A_5A5A}}) begin errors++; $display("FAIL post_stray_done: got resp=%b rdata=%h expected 1 5a5a pattern", d_resp, d_rdata); end
        d_read = 0; mem_resp = 0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst = 0;
        test_reset();
        test_lone_i();
        test_simultaneous();
        test_alternation();
        test_writeback();
        test_reset_mid_and_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
